// File: rtl/irq_aggregator.sv
// ---------------------------------------------------------------------------
// irq_aggregator
//
// Purpose:
//   Avalon-MM slave interrupt controller. It collects N_SRC interrupt lines,
//   latches them into pending bits (edge mode) or follows them (level mode),
//   masks them with ENABLE and drives one registered irq_out to the CPU.
//   ACTIVE_ID gives the highest-priority (lowest index) enabled pending
//   source in one read. MISSED counts cycles in which an edge arrived on a
//   source that was already pending.
//
// Parameters:
//   N_SRC       number of interrupt sources, 1..16 (bit 0 highest priority)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   irq_in      source interrupt lines
//   readdata    registered read data (1-cycle latency)
//   irq_out     aggregated interrupt to CPU
//
// Register map:
//   0 PENDING   (R, W1C on edge-mode bits)
//   1 ENABLE    (R/W)
//   2 EDGE_MODE (R/W, 1 = edge latched, 0 = level)
//   3 ACTIVE_ID (R, bit15 valid, bits3:0 index)
//   4 SW_SET    (W1S on edge-mode bits, reads 0)
//   5 MISSED    (R, any write clears)
//
// Configuration:
//   IRQ_AGGREGATOR_SYNC_EN  when defined, irq_in passes through a two-flop
//                           synchronizer before edge detect / level sampling.
// ---------------------------------------------------------------------------
module irq_aggregator #(
    parameter int N_SRC = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    input  logic [N_SRC-1:0]  irq_in,
    output logic [15:0]       readdata,
    output logic              irq_out
);

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_ENABLE    = 3'd1;
    localparam logic [2:0] ADDR_EDGE_MODE = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
    localparam logic [2:0] ADDR_SW_SET    = 3'd4;
    localparam logic [2:0] ADDR_MISSED    = 3'd5;

    logic [N_SRC-1:0] irq_s;

`ifdef IRQ_AGGREGATOR_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    logic [N_SRC-1:0] pending_q,   pending_d;
    logic [N_SRC-1:0] enable_q,    enable_d;
    logic [N_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [N_SRC-1:0] prev_q,      prev_d;
    logic [15:0]      missed_q,    missed_d;
    logic [15:0]      readdata_q,  readdata_d;
    logic             irq_out_q,   irq_out_d;

    logic             wr_en;
    logic [N_SRC-1:0] wr_bits;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] swset;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] active_vec;
    logic             active_valid;
    logic [3:0]       active_idx;
    logic             missed_hit;
    logic             unused_wdata;

    // Upper writedata bits beyond N_SRC have no register behind them.
    assign unused_wdata = ^writedata;

    // Bus decode. W1C and SW_SET only ever touch edge-mode bits; level-mode
    // bits simply follow their input.
    always_comb begin
        wr_en   = chipselect & ~write_n;
        wr_bits = writedata[N_SRC-1:0];
        w1c     = '0;
        swset   = '0;
        if (wr_en && address == ADDR_PENDING) begin
            w1c = wr_bits & edge_mode_q;
        end
        if (wr_en && address == ADDR_SW_SET) begin
            swset = wr_bits & edge_mode_q;
        end
    end

    // Pending update. A set (edge or SW_SET) wins over a same-cycle clear.
    // Mode changes only take effect after the EDGE_MODE flop updates, and a
    // level->edge switch keeps the current pending value since pending_q is
    // carried straight through.
    always_comb begin
        edge_det   = irq_s & ~prev_q;
        prev_d     = irq_s;
        pending_d  = (edge_mode_q & ((pending_q & ~w1c) | edge_det | swset))
                   | (~edge_mode_q & irq_s);
        missed_hit = |(edge_mode_q & edge_det & pending_q & ~w1c);
    end

    // MISSED counts at most one per cycle, saturates, and any write clears it
    // (clear beats a same-cycle increment).
    always_comb begin
        missed_d = missed_q;
        if (wr_en && address == ADDR_MISSED) begin
            missed_d = '0;
        end else if (missed_hit && missed_q != 16'hFFFF) begin
            missed_d = missed_q + 16'd1;
        end
    end

    always_comb begin
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        if (wr_en && address == ADDR_ENABLE) begin
            enable_d = wr_bits;
        end
        if (wr_en && address == ADDR_EDGE_MODE) begin
            edge_mode_d = wr_bits;
        end
    end

    // Priority encoder: scanning from the top down leaves the lowest index.
    always_comb begin
        active_vec   = pending_q & enable_q;
        active_valid = |active_vec;
        active_idx   = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active_vec[i]) begin
                active_idx = 4'(i);
            end
        end
        irq_out_d = active_valid;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_PENDING:   readdata_d[N_SRC-1:0] = pending_q;
            ADDR_ENABLE:    readdata_d[N_SRC-1:0] = enable_q;
            ADDR_EDGE_MODE: readdata_d[N_SRC-1:0] = edge_mode_q;
            ADDR_ACTIVE_ID: begin
                if (active_valid) begin
                    readdata_d = {1'b1, 11'd0, active_idx};
                end
            end
            ADDR_MISSED:    readdata_d = missed_q;
            default:        readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '1;
            prev_q      <= '0;
            missed_q    <= '0;
            readdata_q  <= '0;
            irq_out_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            prev_q      <= prev_d;
            missed_q    <= missed_d;
            readdata_q  <= readdata_d;
            irq_out_q   <= irq_out_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// ---------------------------------------------------------------------------
// tb_irq_aggregator
//
// Directed scenarios followed by randomized bus/irq traffic. A behavioural
// model tracks each source as a bit in plain arrays and predicts readdata
// and irq_out one clock at a time.
// ---------------------------------------------------------------------------
module tb_irq_aggregator;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [15:0]   writedata = '0;
    logic [N-1:0]  irq_in = '0;
    logic [15:0]   readdata;
    logic          irq_out;

    int tests_run = 0;
    int tests_failed = 0;

    irq_aggregator #(.N_SRC(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_in     (irq_in),
        .readdata   (readdata),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_pend [N];
    bit          m_en   [N];
    bit          m_edge [N];
    bit          m_prev [N];
    int          m_missed;
    logic [15:0] m_rd;
    bit          m_irq;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_en[i]   = 1'b0;
            m_edge[i] = 1'b1;
            m_prev[i] = 1'b0;
        end
        m_missed = 0;
        m_rd     = '0;
        m_irq    = 1'b0;
    endtask

    // One clock of the model, from the inputs seen at this edge.
    task automatic model_step();
        bit          wr;
        int          first;
        bit          lost;
        bit          nxt [N];
        bit          e, clr, set;
        logic [15:0] rd;
        wr    = chipselect && !write_n;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i] && first < 0) first = i;
        end
        rd = '0;
        case (address)
            3'd0: for (int i = 0; i < N; i++) rd[i] = m_pend[i];
            3'd1: for (int i = 0; i < N; i++) rd[i] = m_en[i];
            3'd2: for (int i = 0; i < N; i++) rd[i] = m_edge[i];
            3'd3: if (first >= 0) rd = 16'h8000 + 16'(first);
            3'd5: rd = 16'(m_missed);
            default: rd = '0;
        endcase
        m_irq = (first >= 0);
        lost  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                e   = irq_in[i] && !m_prev[i];
                clr = wr && address == 3'd0 && writedata[i];
                set = wr && address == 3'd4 && writedata[i];
                if (e && m_pend[i] && !clr) lost = 1'b1;
                nxt[i] = (m_pend[i] && !clr) || e || set;
            end else begin
                nxt[i] = irq_in[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = nxt[i];
            m_prev[i] = irq_in[i];
            if (wr && address == 3'd1) m_en[i]   = writedata[i];
            if (wr && address == 3'd2) m_edge[i] = writedata[i];
        end
        if (wr && address == 3'd5) m_missed = 0;
        else if (lost && m_missed < 65535) m_missed = m_missed + 1;
        m_rd = rd;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [15:0] exp_rd [8];
        exp_rd = '{16'h0000, 16'h0000, 16'h000F, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
        reset_n = 1'b0;
        model_reset();
        #23;
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_irq_out: got %b expected 0", irq_out);
        end
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_readdata: got %h expected 0000", readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a));
            tests_run++;
            if (readdata !== exp_rd[a]) begin
                tests_failed++;
                $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, readdata, exp_rd[a]);
            end
        end
    endtask

    task automatic test_edge_pulse();
        wr_reg(3'd1, 16'h0001);
        irq_in = 4'b0001;
        step();
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pulse_irq_early: got %b expected 0", irq_out);
        end
        irq_in = 4'b0000;
        step();
        tests_run++;
        if (irq_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pulse_irq_out: got %b expected 1", irq_out);
        end
        rd_reg(3'd0);
        tests_run++;
        if (readdata !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL pulse_pending: got %h expected 0001", readdata);
        end
        rd_reg(3'd3);
        tests_run++;
        if (readdata !== 16'h8000) begin
            tests_failed++;
            $display("[TB] FAIL pulse_active_id: got %h expected 8000", readdata);
        end
        wr_reg(3'd0, 16'h0001);
        tests_run++;
        if (irq_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL w1c_irq_hold: got %b expected 1", irq_out);
        end
        rd_reg(3'd0);
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL w1c_irq_drop: got %b expected 0", irq_out);
        end
    endtask

    task automatic test_priority();
        wr_reg(3'd1, 16'h000F);
        irq_in = 4'b0110;
        step();
        irq_in = 4'b0000;
        step();
        rd_reg(3'd3);
        tests_run++;
        if (readdata !== 16'h8001) begin
            tests_failed++;
            $display("[TB] FAIL prio_active_id: got %h expected 8001", readdata);
        end
        wr_reg(3'd0, 16'h0002);
        rd_reg(3'd3);
        tests_run++;
        if (readdata !== 16'h8002) begin
            tests_failed++;
            $display("[TB] FAIL prio_after_clear: got %h expected 8002", readdata);
        end
        wr_reg(3'd0, 16'h000F);
    endtask

    task automatic test_missed();
        wr_reg(3'd5, 16'h0000);
        for (int p = 0; p < 3; p++) begin
            irq_in = 4'b0001;
            step();
            irq_in = 4'b0000;
            step();
        end
        rd_reg(3'd0);
        tests_run++;
        if (readdata[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL missed_pending0: got %b expected 1", readdata[0]);
        end
        rd_reg(3'd5);
        tests_run++;
        if (readdata !== 16'h0002) begin
            tests_failed++;
            $display("[TB] FAIL missed_count: got %h expected 0002", readdata);
        end
        wr_reg(3'd5, 16'h1234);
        rd_reg(3'd5);
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL missed_clear: got %h expected 0000", readdata);
        end
        wr_reg(3'd0, 16'h000F);
    endtask

    task automatic test_level();
        wr_reg(3'd2, 16'h000E);
        irq_in = 4'b0001;
        step();
        rd_reg(3'd0);
        tests_run++;
        if (readdata[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL level_follow: got %b expected 1", readdata[0]);
        end
        wr_reg(3'd0, 16'h0001);
        rd_reg(3'd0);
        tests_run++;
        if (readdata[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL level_w1c_ignored: got %b expected 1", readdata[0]);
        end
        irq_in = 4'b0000;
        step();
        rd_reg(3'd0);
        tests_run++;
        if (readdata[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL level_drop: got %b expected 0", readdata[0]);
        end
        wr_reg(3'd2, 16'h000F);
    endtask

    task automatic test_w1c_race();
        irq_in = 4'b1000;
        step();
        irq_in = 4'b0000;
        step();
        wr_reg(3'd5, 16'h0000);
        // Clear and a fresh rising edge on the same bit in one cycle
        irq_in = 4'b1000;
        wr_reg(3'd0, 16'h0008);
        rd_reg(3'd0);
        tests_run++;
        if (readdata[3] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL race_pending3: got %b expected 1", readdata[3]);
        end
        rd_reg(3'd5);
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL race_missed: got %h expected 0000", readdata);
        end
        irq_in = 4'b0000;
        wr_reg(3'd0, 16'h000F);
        wr_reg(3'd1, 16'h0004);
        wr_reg(3'd4, 16'h0004);
        rd_reg(3'd0);
        tests_run++;
        if (readdata !== 16'h0004) begin
            tests_failed++;
            $display("[TB] FAIL swset_pending: got %h expected 0004", readdata);
        end
        tests_run++;
        if (irq_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL swset_irq_out: got %b expected 1", irq_out);
        end
        rd_reg(3'd4);
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL swset_reads0: got %h expected 0000", readdata);
        end
        wr_reg(3'd0, 16'h000F);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            irq_in     = N'($urandom_range(0, 15));
            address    = 3'($urandom_range(0, 7));
            writedata  = 16'($urandom);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            step();
            tests_run++;
            if (readdata !== m_rd) begin
                tests_failed++;
                $display("[TB] FAIL rand_readdata cyc %0d: got %h expected %h", c, readdata, m_rd);
            end
            tests_run++;
            if (irq_out !== m_irq) begin
                tests_failed++;
                $display("[TB] FAIL rand_irq_out cyc %0d: got %b expected %b", c, irq_out, m_irq);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        irq_in     = '0;
        step();
    endtask

    task automatic test_mid_reset();
        wr_reg(3'd2, 16'h000F);
        wr_reg(3'd0, 16'h000F);
        wr_reg(3'd1, 16'h0001);
        irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        address = 3'd1;
        step();
        tests_run++;
        if (irq_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq_out);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (irq_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_irq_out: got %b expected 0", irq_out);
        end
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_readdata: got %h expected 0000", readdata);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        rd_reg(3'd2);
        tests_run++;
        if (readdata !== 16'h000F) begin
            tests_failed++;
            $display("[TB] FAIL midrst_edge_mode: got %h expected 000F", readdata);
        end
        rd_reg(3'd1);
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_enable: got %h expected 0000", readdata);
        end
        rd_reg(3'd0);
        tests_run++;
        if (readdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pending: got %h expected 0000", readdata);
        end
    endtask

    initial begin
        test_reset();
        test_edge_pulse();
        test_priority();
        test_missed();
        test_level();
        test_w1c_race();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
